// File: rtl/sub3_pipeline.sv
// Valid/ready pipeline recovering c = y - a - b with a full-precision borrow flag.
// Define SUB3_PIPELINE_MID_STAGE_EN to split the subtraction across an extra stage (latency 3 instead of 2).
module sub3_pipeline #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             borrow
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_y, s1_a, s1_b;
    logic             s1_adv;
    logic             out_load;
    logic             src_adv;
    logic [WIDTH+1:0] diff;

    assign out_load = !out_valid || out_ready;

`ifdef SUB3_PIPELINE_MID_STAGE_EN
    logic             s2_valid;
    logic [WIDTH:0]   s2_d;
    logic [WIDTH-1:0] s2_b;
    logic             s2_adv;

    assign s2_adv  = s2_valid && out_load;
    assign s1_adv  = s1_valid && (!s2_valid || s2_adv);
    assign src_adv = s2_adv;
    // s2_d is a signed (WIDTH+1)-bit partial difference; sign-extend before the second step
    assign diff    = {s2_d[WIDTH], s2_d} - {2'b00, s2_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (!s2_valid || s2_adv) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv) begin
            s2_d <= {1'b0, s1_y} - {1'b0, s1_a};
            s2_b <= s1_b;
        end
    end
`else
    assign s1_adv  = s1_valid && out_load;
    assign src_adv = s1_adv;
    assign diff    = {2'b00, s1_y} - {2'b00, s1_a} - {2'b00, s1_b};
`endif

    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_y <= y;
            s1_a <= a;
            s1_b <= b;
        end
    end

    // Any negative result lies in [-(2^(W+1)-2), -1], so either of the top two bits marks it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            borrow    <= 1'b0;
        end else begin
            if (out_load) begin
                out_valid <= src_adv;
            end
            if (src_adv) begin
                c      <= diff[WIDTH-1:0];
                borrow <= |diff[WIDTH+1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sub3_pipeline.sv
// Self-checking bench for sub3_pipeline: vector table, scoreboard monitor and corner-case sequences.
module tb_sub3_pipeline;

    localparam int W = 16;
`ifdef SUB3_PIPELINE_MID_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int CAP = LAT;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, borrow;
    logic [W-1:0] y, a, b, c;

    sub3_pipeline #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .borrow(borrow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] y, a, b, c;
        logic         borrow;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int popped = 0;
    logic [W:0] sb[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [W:0] model(logic [W-1:0] ty, logic [W-1:0] ta, logic [W-1:0] tb);
        int t;
        t = int'(ty) - int'(ta) - int'(tb);
        return {(t < 0) ? 1'b1 : 1'b0, t[W-1:0]};
    endfunction

    // Output monitor: scoreboard pop on every handshake, stability check while stalled
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_c;
    logic         prev_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_c", 32'(c), 32'(prev_c));
                check("hold_borrow", 32'(borrow), 32'(prev_b));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(c), 32'hdead);
                end else begin
                    logic [W:0] e;
                    e = sb.pop_front();
                    popped++;
                    check("sb_c", 32'(c), 32'(e[W-1:0]));
                    check("sb_borrow", 32'(borrow), 32'(e[W]));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c;
            prev_b     = borrow;
        end
    end

    task automatic send(input logic [W-1:0] ty, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W:0] exp);
        bit ok;
        ok = 1'b0;
        y = ty; a = ta; b = tb; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    vec_t bp[4];

    initial begin
        int first, last, cnt, acc, p0;
        logic [W:0] e;

        vecs[0] = '{16'd100,  16'd30,   16'd20,   16'd50,   1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'h1000, 16'h0800, 16'h0801, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0002, 1'b1};
        vecs[7] = '{16'h1234, 16'h0034, 16'h0200, 16'h1000, 1'b0};
        vecs[8] = '{16'h8000, 16'h4000, 16'h4000, 16'h0000, 1'b0};
        vecs[9] = '{16'h8000, 16'h4000, 16'h4001, 16'hFFFF, 1'b1};

        bp[0] = '{16'd500, 16'd100, 16'd50,  16'd350, 1'b0};
        bp[1] = '{16'd10,  16'd20,  16'd30,  16'hFFD8, 1'b1};
        bp[2] = '{16'd7,   16'd3,   16'd2,   16'd2,   1'b0};
        bp[3] = '{16'hABCD, 16'h0BCD, 16'h0001, 16'h9FFF, 1'b0};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        y = '0; a = '0; b = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_c", 32'(c), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency of a single transfer
        out_ready = 1'b1;
        send(16'd100, 16'd30, 16'd20, model(16'd100, 16'd30, 16'd20));
        in_valid = 1'b0;
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        for (int e2 = 2; e2 <= LAT; e2++) begin
            @(posedge clk);
            #1;
            check("lat_valid", 32'(out_valid), (e2 == LAT) ? 32'd1 : 32'd0);
        end
        check("lat_c", 32'(c), 32'd50);
        check("lat_borrow", 32'(borrow), 32'd0);
        drain();

        // Vector table, back-to-back with free-running output
        for (int i = 0; i < 10; i++)
            send(vecs[i].y, vecs[i].a, vecs[i].b, {vecs[i].borrow, vecs[i].c});
        in_valid = 1'b0;
        drain();

        // Ten-cycle random burst: expect an unbroken run of ten results
        first = -1; last = -1; cnt = 0;
        for (int e2 = 1; e2 <= 10 + LAT + 3; e2++) begin
            if (e2 <= 10) begin
                y = W'($urandom); a = W'($urandom); b = W'($urandom);
                in_valid = 1'b1;
                @(negedge clk);
                check("burst_in_ready", 32'(in_ready), 32'd1);
                sb.push_back(model(y, a, b));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                cnt++;
                if (first < 0) first = e2;
                last = e2;
            end
        end
        check("burst_count", 32'(cnt), 32'd10);
        check("burst_first_edge", 32'(first), 32'(LAT));
        check("burst_contiguous", 32'(last - first + 1), 32'd10);
        drain();

        // Backpressure: output stalled for five cycles while four sets are offered
        p0 = popped;
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (acc < 4) begin
                y = bp[acc].y; a = bp[acc].a; b = bp[acc].b; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back({bp[acc].borrow, bp[acc].c});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 32'(acc), 32'(CAP));
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = acc; i < 4; i++)
            send(bp[i].y, bp[i].a, bp[i].b, {bp[i].borrow, bp[i].c});
        in_valid = 1'b0;
        drain();
        check("bp_results", 32'(popped - p0), 32'd4);

        // Reset with two results in flight; the next set must be the first out
        out_ready = 1'b0;
        send(16'd900, 16'd100, 16'd100, model(16'd900, 16'd100, 16'd100));
        send(16'd40,  16'd1,   16'd2,   model(16'd40, 16'd1, 16'd2));
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_c", 32'(c), 32'd0);
        check("mrst_borrow", 32'(borrow), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        y = 16'd1234; a = 16'd200; b = 16'd34; in_valid = 1'b1;
        e = model(16'd1234, 16'd200, 16'd34);
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_first_c", 32'(c), 32'd1000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sub3_pipeline.md
SUB3_PIPELINE -- requirements
Module: sub3_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream holds a valid operand set.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts the operand set this cycle.
REQ-006 SHALL have port y, input, WIDTH bits: minuend, the total produced by the three-operand adder.
REQ-007 SHALL have port a, input, WIDTH bits: first subtrahend.
REQ-008 SHALL have port b, input, WIDTH bits: second subtrahend.
REQ-009 SHALL have port out_valid, output, 1 bit: c and borrow hold a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.
REQ-011 SHALL have port c, output, WIDTH bits: recovered operand, (y - a - b) mod 2^WIDTH.
REQ-012 SHALL have port borrow, output, 1 bit: 1 when the true y - a - b is negative.

Function
REQ-013 SHALL accept a transfer on a rising edge where in_valid and in_ready are both 1; the transfer SHALL be ignored when in_valid is 0.
REQ-014 SHALL register y, a and b in an input stage S1; there SHALL be no combinational path from y, a or b to c.
REQ-015 SHALL compute the difference using at least WIDTH+2 bits, then output the low WIDTH bits on c.
REQ-016 SHALL set borrow to 1 exactly when y < a + b, compared as unsigned values at full precision.
REQ-017 SHALL give each stage its own valid bit; a stage SHALL load when it is empty or when its contents move downstream in the same cycle.
REQ-018 SHALL drive in_ready = !S1_valid || S1_advances; this is a combinational chain back from out_ready, with no skid buffer.
REQ-019 SHALL have a latency of 2 edges from accept to out_valid=1 without MID_STAGE_EN, and 3 edges with it.
REQ-020 SHALL sustain one result per cycle while out_ready is held at 1.
REQ-021 SHALL hold c, borrow and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve input order; no result SHALL be dropped or duplicated under any backpressure pattern.
REQ-023 SHALL, on a simultaneous accept at the input and consume at the output, advance every stage in that cycle with no bubble.
REQ-024 SHALL treat WIDTH-bit wrap-around as defined behaviour: c wraps modulo 2^WIDTH and borrow records the wrap.

Reset
REQ-025 SHALL, while rst_n=0, clear all stage valid bits immediately (asynchronously), giving out_valid=0 and in_ready=1.
REQ-026 SHALL, while rst_n=0, force c=0 and borrow=0.
REQ-027 SHALL leave internal data registers other than c and borrow without reset.
REQ-028 SHALL discard all in-flight results when reset is asserted mid-operation.
REQ-029 SHALL accept new input on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro SUB3_PIPELINE_MID_STAGE_EN defined, add a middle stage S2 holding d = y - a (WIDTH+1 bits) together with b; the output stage then computes c = d - b. Latency is 3.
REQ-031 SHALL, without SUB3_PIPELINE_MID_STAGE_EN, compute y - a - b in a single step from S1 into the output stage. Latency is 2.
REQ-032 SHALL produce identical c, borrow and ordering in both configurations, differing only in latency and capacity (2 versus 3 results in flight).

Verification
REQ-033 SHALL cover: y=100, a=30, b=20 with out_ready=1 -> c=50, borrow=0, out_valid=1 two edges after accept (three with the macro).
REQ-034 SHALL cover: y=0, a=1, b=0 -> c=0xFFFF, borrow=1; and y=0xFFFF, a=0xFFFF, b=0xFFFF -> c=0x0001, borrow=1.
REQ-035 SHALL cover: y=0xFFFF, a=0x8000, b=0x7FFF -> c=0x0000, borrow=0 (exact boundary, no borrow).
REQ-036 SHALL cover: stream of 4 sets with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts (3 with the macro); after out_ready=1, all 4 results arrive in order with none lost.
REQ-037 SHALL cover: rst_n pulsed low for 1 cycle with 2 results in flight -> out_valid=0, c=0, borrow=0 at once; a new set accepted next is the first result out.
REQ-038 SHALL cover: back-to-back accepts for 10 cycles with out_ready=1 -> 10 consecutive out_valid cycles, each c equal to y-a-b mod 2^16.
